// File: rtl/hazard_ctrl.sv
// hazard_ctrl: per-cycle stall/flush decisions for the 5-stage MIPS front end,
// plus multiply/divide busy sequencing and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             id_branch_taken,
  input  logic             id_hilo_use,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_dst,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_dst,
  input  logic             mdu_start,
  output logic             pc_freeze,
  output logic             ifid_freeze,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MW = $clog2(MDU_LAT) + 1;

  typedef enum logic {IDLE, BUSY} mdu_state_t;

  mdu_state_t       r_state;
  mdu_state_t       w_stateNext;
  logic [MW-1:0]    r_mduCnt;
  logic [MW-1:0]    w_mduCntNext;
  logic [CNT_W-1:0] r_stallCnt;

  logic w_mduBusy;
  logic w_exHit;
  logic w_memHit;
  logic w_loadUse;
  logic w_brDep;
  logic w_mduHaz;
  logic w_stall;

  // Register 0 is hardwired to zero, so a write to it never creates a dependence.
  function automatic logic anyHit(input logic usesRs, input logic [4:0] rs,
                                  input logic usesRt, input logic [4:0] rt,
                                  input logic [4:0] d);
    return (d != 5'd0) && ((usesRs && rs == d) || (usesRt && rt == d));
  endfunction

  assign w_mduBusy = (r_mduCnt != '0);
  assign w_exHit   = anyHit(id_uses_rs, id_rs, id_uses_rt, id_rt, ex_dst);
  assign w_memHit  = anyHit(id_uses_rs, id_rs, id_uses_rt, id_rt, mem_dst);
  assign w_loadUse = ex_mem_read && w_exHit;
  assign w_brDep   = id_is_branch && ((ex_reg_write && w_exHit) || (mem_mem_read && w_memHit));
  assign w_mduHaz  = id_hilo_use && (w_mduBusy || mdu_start);
  assign w_stall   = !reset && (w_loadUse || w_brDep || w_mduHaz);

  // A stalled branch is re-evaluated next cycle, so stall suppresses the flush.
  assign pc_freeze   = w_stall;
  assign ifid_freeze = w_stall;
  assign idex_bubble = w_stall;
  assign ifid_flush  = !reset && id_branch_taken && !w_stall;
  assign mdu_busy    = !reset && w_mduBusy;
  assign stall_cnt   = r_stallCnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_mduCnt <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_mduCnt <= w_mduCntNext;
    end
  end

  // A start while BUSY is ignored; the count runs down independent of stalls.
  always_comb begin
    w_stateNext  = r_state;
    w_mduCntNext = r_mduCnt;
    case (r_state)
      IDLE: begin
        if (mdu_start) begin
          w_mduCntNext = MW'(MDU_LAT - 1);
          w_stateNext  = BUSY;
        end
      end
      BUSY: begin
        w_mduCntNext = r_mduCnt - MW'(1);
        if (r_mduCnt == MW'(1)) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext  = IDLE;
        w_mduCntNext = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stallCnt <= '0;
    end else if (w_stall && (r_stallCnt != {CNT_W{1'b1}})) begin
      r_stallCnt <= r_stallCnt + CNT_W'(1);
    end
  end

endmodule
